// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: default datapath width,
// ALU select encodings, sequencer FSM states and response flag bit positions.
package alu_seq_pkg;

  // Datapath width of the external ALU.
  localparam int W_DEFAULT = 4;

  // ALU select encodings driven on alu_sel.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  // Bit positions inside rsp_flags = {overflow, carry, zero}.
  localparam int ZERO  = 0;
  localparam int CARRY = 1;
  localparam int OVF   = 2;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Only add and subtract produce meaningful carry/overflow from the ALU.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer acting as the initiator for an external
// combinational ALU. Commands are registered onto the ALU inputs, the result
// and flags are captured one cycle later, and the result can optionally be
// written back into an internal accumulator for chained arithmetic.
//
// Optional feature macro: ALU_SEQ_STICKY_OVF_EN adds sticky_ovf (output) and
// cmd_clr_sticky (input), a sticky record of any captured overflow.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready depends only on FSM state and rst (never on cmd_valid);
// rsp_valid depends only on FSM state, and once raised it stays high with
// rsp_result/rsp_flags unchanged until the edge where rsp_ready is sampled high.
module alu_cmd_seq
  import alu_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  // Command channel
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_use_acc,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_wb,
  // External ALU
  output logic [2:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  // Response channel
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  // Accumulator
  output logic [W-1:0] acc,
`ifdef ALU_SEQ_STICKY_OVF_EN
  input  logic         cmd_clr_sticky,
  output logic         sticky_ovf,
`endif
  // Debug view of the FSM state
  output logic [1:0]   dbg_state
);

  seq_state_e   state_q, state_d;
  logic [2:0]   sel_q, sel_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         wb_q, wb_d;
  logic [W-1:0] result_q, result_d;
  logic [2:0]   flags_q, flags_d;
  logic [W-1:0] acc_q, acc_d;
  logic         accept;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic         sticky_q, sticky_d;
`endif

  // Ready only in IDLE, and held low for the whole cycle that rst is high.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  assign alu_sel    = sel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign acc        = acc_q;
  assign dbg_state  = state_q;
`ifdef ALU_SEQ_STICKY_OVF_EN
  assign sticky_ovf = sticky_q;
`endif

  // Next-state logic: operand latch in IDLE, capture in EXEC, hold in RESP.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    wb_d     = wb_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
`ifdef ALU_SEQ_STICKY_OVF_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d   = cmd_op;
          // acc is read as it stands now; earlier write-backs are complete
          // because only one operation is ever in flight.
          a_d     = cmd_use_acc ? acc_q : cmd_a;
          b_d     = cmd_b;
          wb_d    = cmd_wb;
          state_d = EXEC;
`ifdef ALU_SEQ_STICKY_OVF_EN
          if (cmd_clr_sticky) begin
            sticky_d = 1'b0;
          end
`endif
        end
      end
      EXEC: begin
        // Operands have been stable at the ALU for this whole cycle.
        result_d = alu_result;
        if (is_arith_op(sel_q)) begin
          flags_d[OVF]   = alu_overflow;
          flags_d[CARRY] = alu_carry;
          flags_d[ZERO]  = alu_zero;
        end else begin
          // Carry/overflow are meaningless for logic and compare ops.
          flags_d[OVF]   = 1'b0;
          flags_d[CARRY] = 1'b0;
          flags_d[ZERO]  = (alu_result == '0);
        end
        if (wb_q) begin
          acc_d = alu_result;
        end
`ifdef ALU_SEQ_STICKY_OVF_EN
        if (flags_d[OVF]) begin
          sticky_d = 1'b1;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; rst aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wb_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
`ifdef ALU_SEQ_STICKY_OVF_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wb_q     <= wb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
`ifdef ALU_SEQ_STICKY_OVF_EN
      sticky_q <= sticky_d;
`endif
    end
  end

endmodule
